// File: rtl/prio_enc_rr_if.sv
// Request/result bundle between a requester and the priority encoder.
// Latency: none (wires only).
// Backpressure: ready from master, valid_bit from slave; slave holds results while !ready.
interface prio_enc_rr_if #(
    parameter int WIDTH = 8,
    parameter int OUT_W = 3
);
    logic             enable;
    logic             mode;
    logic [WIDTH-1:0] in;
    logic             ready;
    logic [OUT_W-1:0] out;
    logic [WIDTH-1:0] grant;
    logic             multi;
    logic             valid_bit;

    // Requester side: drives requests and acceptance, observes the result.
    modport master (
        output enable, mode, in, ready,
        input  out, grant, multi, valid_bit
    );

    // Encoder side: consumes requests, produces the registered result.
    modport slave (
        input  enable, mode, in, ready,
        output out, grant, multi, valid_bit
    );
endinterface

// File: rtl/prio_enc_rr.sv
// Registered priority encoder, fixed (highest index) or round-robin priority per sample.
// Latency: 1 cycle from sampling edge to valid_bit.
// Backpressure: result held stable while valid_bit & !ready; inputs ignored until freed.
module prio_enc_rr #(
    parameter int WIDTH = 8,
    parameter int OUT_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    prio_enc_rr_if.slave   bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [OUT_W-1:0] ptr;
    logic [OUT_W-1:0] fix_win;
    logic [OUT_W-1:0] rr_win;
    logic [OUT_W-1:0] win;
    logic             free;
    logic             sample;
    logic             multi_nxt;

    assign free      = !bus.valid_bit || bus.ready;
    assign sample    = bus.enable && (|bus.in);
    assign multi_nxt = ($countones(bus.in) > 1);
    assign win       = bus.mode ? rr_win : fix_win;

    // Fixed priority: scan upward so the highest set index is the last to overwrite.
    always_comb begin
        fix_win = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.in[i]) begin
                fix_win = OUT_W'(i);
            end
        end
    end

    // Round-robin: walk from lowest priority (distance WIDTH, i.e. ptr itself) to
    // highest (distance 1, i.e. ptr-1), so the nearest set bit below ptr wins, wrapping at 0.
    always_comb begin
        logic [OUT_W-1:0] idx;
        rr_win = '0;
        idx    = '0;
        for (int k = WIDTH; k >= 1; k--) begin
            idx = OUT_W'((int'(ptr) + WIDTH - k) % WIDTH);
            if (bus.in[idx]) begin
                rr_win = idx;
            end
        end
    end

    // Result register and rr pointer: load on sample, clear when freed without a sample,
    // hold everything while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out       <= '0;
            bus.grant     <= '0;
            bus.multi     <= 1'b0;
            bus.valid_bit <= 1'b0;
            ptr           <= '0;
        end else if (free) begin
            if (sample) begin
                bus.out       <= win;
                bus.grant     <= ONE << win;
                bus.multi     <= multi_nxt;
                bus.valid_bit <= 1'b1;
                if (bus.mode) begin
                    ptr <= win;
                end
            end else begin
                bus.out       <= '0;
                bus.grant     <= '0;
                bus.multi     <= 1'b0;
                bus.valid_bit <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prio_enc_rr.sv
// Bench for prio_enc_rr (WIDTH=8): directed table, hand sequences, randomized vs reference model.
// Latency: checks one cycle after each sampling edge.
// Backpressure: exercises ready stalls, enable gating and async reset mid-handshake.
module tb_prio_enc_rr;

    localparam int WIDTH = 8;
    localparam int OUT_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    prio_enc_rr_if #(.WIDTH(WIDTH), .OUT_W(OUT_W)) bus ();

    prio_enc_rr #(.WIDTH(WIDTH), .OUT_W(OUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic       m_valid;
    int         m_out;
    logic       m_multi;
    int         m_ptr;

    typedef struct packed {
        logic       en;
        logic       md;
        logic [7:0] req;
        logic       rdy;
        logic       e_valid;
        logic [2:0] e_out;
        logic [7:0] e_grant;
        logic       e_multi;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Winner from the rules: fixed = highest set index; round-robin = highest set index
    // strictly below the pointer, otherwise the highest set index overall.
    function automatic int model_win(input logic [7:0] v, input logic md, input int p);
        int hi_all;
        int hi_below;
        hi_all   = -1;
        hi_below = -1;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                hi_all = i;
                if (i < p) hi_below = i;
            end
        end
        if (!md) return hi_all;
        return (hi_below >= 0) ? hi_below : hi_all;
    endfunction

    function automatic int popcnt(input logic [7:0] v);
        int c;
        c = 0;
        for (int i = 0; i < WIDTH; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_out   = 0;
        m_multi = 1'b0;
        m_ptr   = 0;
    endtask

    // Advance the model with the current inputs, then clock the DUT and settle.
    task automatic step();
        int w;
        if (!m_valid || bus.ready) begin
            if (bus.enable && bus.in != 8'h00) begin
                w       = model_win(bus.in, bus.mode, m_ptr);
                m_valid = 1'b1;
                m_out   = w;
                m_multi = (popcnt(bus.in) > 1);
                if (bus.mode) m_ptr = w;
            end else begin
                m_valid = 1'b0;
                m_out   = 0;
                m_multi = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, int'(bus.valid_bit), 0);
        check({tag, "_out"},   int'(bus.out),       0);
        check({tag, "_grant"}, int'(bus.grant),     0);
        check({tag, "_multi"}, int'(bus.multi),     0);
    endtask

    // Pulse reset in the middle of a cycle and confirm outputs clear without a clock edge.
    task automatic pulse_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_zero(tag);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_model(input string tag);
        check({tag, "_valid"}, int'(bus.valid_bit), int'(m_valid));
        check({tag, "_out"},   int'(bus.out),       m_out);
        check({tag, "_grant"}, int'(bus.grant),     m_valid ? (1 << m_out) : 0);
        check({tag, "_multi"}, int'(bus.multi),     int'(m_multi));
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.mode   = 1'b0;
        bus.in     = 8'h00;
        bus.ready  = 1'b0;
        model_reset();

        // Directed table, applied in order from the reset state (pointer starts at 0).
        //           en    md    req    rdy   v     out   grant  multi
        tbl[0]  = '{1'b1, 1'b0, 8'h45, 1'b1, 1'b1, 3'd6, 8'h40, 1'b1}; // fixed: highest wins
        tbl[1]  = '{1'b1, 1'b1, 8'h21, 1'b1, 1'b1, 3'd5, 8'h20, 1'b1}; // rr P=0 -> 5
        tbl[2]  = '{1'b1, 1'b1, 8'h21, 1'b1, 1'b1, 3'd0, 8'h01, 1'b1}; // rr P=5 -> 0
        tbl[3]  = '{1'b1, 1'b1, 8'h21, 1'b1, 1'b1, 3'd5, 8'h20, 1'b1}; // wrap back to 5
        tbl[4]  = '{1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0}; // enable low
        tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0}; // no requests
        tbl[6]  = '{1'b1, 1'b1, 8'h08, 1'b1, 1'b1, 3'd3, 8'h08, 1'b0}; // single bit, P->3
        tbl[7]  = '{1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0}; // stall holds
        tbl[8]  = '{1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0}; // enable low keeps result
        tbl[10] = '{1'b1, 1'b0, 8'h80, 1'b1, 1'b1, 3'd7, 8'h80, 1'b0}; // accept + reload
        tbl[11] = '{1'b1, 1'b1, 8'h18, 1'b1, 1'b1, 3'd4, 8'h10, 1'b1}; // rr P=3 wraps -> 4
        tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd4, 8'h10, 1'b1}; // hold
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0}; // accepted, cleared

        #3;
        check_zero("reset");
        #9;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_zero("post_reset");

        for (int i = 0; i < 14; i++) begin
            bus.enable = tbl[i].en;
            bus.mode   = tbl[i].md;
            bus.in     = tbl[i].req;
            bus.ready  = tbl[i].rdy;
            step();
            check($sformatf("tbl%0d_valid", i), int'(bus.valid_bit), int'(tbl[i].e_valid));
            check($sformatf("tbl%0d_out", i),   int'(bus.out),       int'(tbl[i].e_out));
            check($sformatf("tbl%0d_grant", i), int'(bus.grant),     int'(tbl[i].e_grant));
            check($sformatf("tbl%0d_multi", i), int'(bus.multi),     int'(tbl[i].e_multi));
        end

        // Pointer is 4 here; load a valid result, reset mid-cycle, then prove P went to 0.
        bus.enable = 1'b1;
        bus.mode   = 1'b0;
        bus.in     = 8'h02;
        bus.ready  = 1'b1;
        step();
        check("pre_rst_valid", int'(bus.valid_bit), 1);
        check("pre_rst_out",   int'(bus.out),       1);
        pulse_reset("midrst");
        bus.mode = 1'b1;
        bus.in   = 8'h11;
        step();
        check("after_rst_out",   int'(bus.out),       4);
        check("after_rst_valid", int'(bus.valid_bit), 1);

        // All requests held in round-robin: 7 down to 0 then wrap to 7, no bubbles.
        pulse_reset("rst2");
        bus.in = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("rrff%0d_out", i),   int'(bus.out),       7 - (i % 8));
            check($sformatf("rrff%0d_valid", i), int'(bus.valid_bit), 1);
        end

        // Randomized traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            int kind;
            bus.enable = ($urandom_range(3, 0) != 0);
            bus.mode   = $urandom_range(1, 0) != 0;
            bus.ready  = ($urandom_range(9, 0) < 7);
            kind       = $urandom_range(5, 0);
            if (kind == 0)      bus.in = 8'h00;
            else if (kind == 1) bus.in = 8'h01 << $urandom_range(7, 0);
            else                bus.in = 8'($urandom);
            if ($urandom_range(63, 0) == 0) begin
                pulse_reset("rnd_rst");
            end else begin
                step();
                check_model("rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
